dvi_timing_gen: RTL and testbench

Video timing controller for the DVI transmit path. It runs in the pixel clock domain and generates the horizontal and vertical counters, sync pulses and display-enable for one video mode. It issues pixel fetch requests with coordinates to a pixel source. It re-aligns the returned pixel data with the delayed sync and DE so the output bundle feeds the DVI core inputs (`hsync_i`, `vsync_i`, `de_i`, `pix_r/g/b`) directly.

---
 rtl/dvi_timing_pkg.sv | 46 ++++
 rtl/dvi_timing_gen_sig_delay.sv | 33 +++
 rtl/dvi_timing_gen.sv | 154 +++++++++++++++
 tb/tb_dvi_timing_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_timing_pkg.sv
// Purpose: shared video-mode constants and timing helpers for the DVI timing generator.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package dvi_timing_pkg;

  // One complete video mode: horizontal and vertical segment lengths plus sync polarity.
  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          h_pol;
    bit          v_pol;
  } mode_t;

  // Standard CEA/VESA timings. Polarity 1 = active-high sync.
  localparam mode_t MODE_640x480  = '{640,  16,  96,  48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam mode_t MODE_800x600  = '{800,  40, 128,  88, 600,  1, 4, 23, 1'b1, 1'b1};
  localparam mode_t MODE_1280x720 = '{1280, 110, 40, 220, 720,  5, 5, 20, 1'b1, 1'b1};

  // Total period of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned timing_total(input int unsigned act_len,
                                               input int unsigned fp_len,
                                               input int unsigned sync_len,
                                               input int unsigned bp_len);
    return act_len + fp_len + sync_len + bp_len;
  endfunction

  function automatic int unsigned h_total(input mode_t m);
    return timing_total(m.h_active, m.h_fp, m.h_sync, m.h_bp);
  endfunction

  function automatic int unsigned v_total(input mode_t m);
    return timing_total(m.v_active, m.v_fp, m.v_sync, m.v_bp);
  endfunction

  // True when a counter of width w can represent max_val.
  function automatic bit width_fits(input int unsigned w, input int unsigned max_val);
    return $clog2(max_val + 1) <= w;
  endfunction

endpackage

// File: rtl/dvi_timing_gen_sig_delay.sv
// Purpose: DEPTH-stage by WIDTH-bit shift register, resets to RST_VAL.
// Latency: exactly DEPTH clocks from din to dout.
// Backpressure: none; shifts every clock unconditionally.
module sig_delay #(
  parameter int unsigned          DEPTH   = 2,
  parameter int unsigned          WIDTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // Shift chain; stage 0 takes the new sample, the last stage is the output.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= RST_VAL;
      end
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/dvi_timing_gen.sv
// Purpose: pixel-clock video timing: counters, sync/DE decode, pixel fetch, output re-alignment.
// Latency: fetch request at stage 0; sync/DE/pixel out PIX_LAT+1 clocks later.
// Backpressure: none; source must return data exactly PIX_LAT clocks after each request.
module dvi_timing_gen
  import dvi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = MODE_640x480.h_active,
  parameter int unsigned H_FP     = MODE_640x480.h_fp,
  parameter int unsigned H_SYNC   = MODE_640x480.h_sync,
  parameter int unsigned H_BP     = MODE_640x480.h_bp,
  parameter int unsigned V_ACTIVE = MODE_640x480.v_active,
  parameter int unsigned V_FP     = MODE_640x480.v_fp,
  parameter int unsigned V_SYNC   = MODE_640x480.v_sync,
  parameter int unsigned V_BP     = MODE_640x480.v_bp,
  parameter bit          H_POL    = MODE_640x480.h_pol,
  parameter bit          V_POL    = MODE_640x480.v_pol,
  parameter int unsigned PIX_LAT  = 2,
  parameter int unsigned X_W      = 12,
  parameter int unsigned Y_W      = 12
) (
  input  logic           clk_pix,
  input  logic           rst_n,
  input  logic           en,
  output logic           pix_req,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  input  logic [7:0]     src_r,
  input  logic [7:0]     src_g,
  input  logic [7:0]     src_b,
  output logic           frame_start,
  output logic           line_start,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           de_o,
  output logic [7:0]     pix_r,
  output logic [7:0]     pix_g,
  output logic [7:0]     pix_b
);

  localparam int unsigned H_TOTAL_C = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL_C = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Mis-sized counters or an unsupported source latency are build errors, not runtime cases.
  if (!width_fits(X_W, H_TOTAL_C - 1)) begin : g_xw_chk
    $error("X_W too narrow to hold H_TOTAL-1");
  end
  if (!width_fits(Y_W, V_TOTAL_C - 1)) begin : g_yw_chk
    $error("Y_W too narrow to hold V_TOTAL-1");
  end
  if (PIX_LAT < 1 || PIX_LAT > 15) begin : g_lat_chk
    $error("PIX_LAT must be within 1..15");
  end

  // Segment boundaries in counter width so every compare is width-exact.
  localparam logic [X_W-1:0] H_ACT_C  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_SS_C   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] H_SE_C   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_W-1:0] H_LAST_C = X_W'(H_TOTAL_C - 1);
  localparam logic [Y_W-1:0] V_ACT_C  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_SS_C   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] V_SE_C   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [Y_W-1:0] V_LAST_C = Y_W'(V_TOTAL_C - 1);

  logic           run_q;
  logic           live;
  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           act;
  logic           hs;
  logic           vs;
  logic [2:0]     sync_d;
  logic           tag_d;

  // Reset drops immediately; run_q lets the timing start only after the first clean edge.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign live = en & run_q;

  // Raster counters; held at the origin whenever not running so a re-enable starts a fresh frame.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!live) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST_C) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + Y_W'(1);
    end else begin
      h_cnt <= h_cnt + X_W'(1);
    end
  end

  // Stage-0 decode straight off the counter registers, gated by run state so the first
  // enabled cycle already presents the origin with request and start pulses.
  always_comb begin
    act         = live && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs          = live && (h_cnt >= H_SS_C) && (h_cnt < H_SE_C);
    vs          = live && (v_cnt >= V_SS_C) && (v_cnt < V_SE_C);
    pix_req     = act;
    pix_x       = act ? h_cnt : '0;
    pix_y       = act ? v_cnt : '0;
    frame_start = live && (h_cnt == '0) && (v_cnt == '0);
    line_start  = live && (h_cnt == '0);
  end

  // Sync/DE timing travels alongside the outstanding pixel fetch.
  sig_delay #(
    .DEPTH   (PIX_LAT),
    .WIDTH   (3),
    .RST_VAL (3'b000)
  ) u_sync_dly (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .din     ({act, hs, vs}),
    .dout    (sync_d)
  );

  // Data-valid tag: marks the cycle in which src_* carries a requested pixel.
  sig_delay #(
    .DEPTH   (PIX_LAT),
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_tag_dly (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .din     (pix_req),
    .dout    (tag_d)
  );

  // Shared output register: aligned sync at configured polarity, DE, and pixel data blanked outside DE.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      de_o    <= 1'b0;
      hsync_o <= ~H_POL;
      vsync_o <= ~V_POL;
      pix_r   <= 8'h00;
      pix_g   <= 8'h00;
      pix_b   <= 8'h00;
    end else begin
      de_o    <= sync_d[2];
      hsync_o <= sync_d[1] ^ ~H_POL;
      vsync_o <= sync_d[0] ^ ~V_POL;
      pix_r   <= tag_d ? src_r : 8'h00;
      pix_g   <= tag_d ? src_g : 8'h00;
      pix_b   <= tag_d ? src_b : 8'h00;
    end
  end

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Purpose: self-checking bench for dvi_timing_gen using a reduced video mode and two latencies.
// Latency: checks stage-0 outputs each cycle and aligned outputs PIX_LAT+1 cycles later.
// Backpressure: n/a; the source model answers every request after a fixed latency.
module tb_dvi_timing_gen;

  localparam int HA = 16, HF = 4, HSW = 6, HB = 6;
  localparam int VA = 8,  VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;   // 32
  localparam int VT = VA + VF + VSW + VB;   // 15
  localparam int LAT_A = 2;
  localparam int LAT_B = 5;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic rst_n, en;

  logic        req_a, fs_a, ls_a, hs_a, vs_a, de_a;
  logic [11:0] x_a, y_a;
  logic [7:0]  sr_a, sg_a, sb_a, pr_a, pg_a, pb_a;
  logic        req_b, fs_b, ls_b, hs_b, vs_b, de_b;
  logic [11:0] x_b, y_b;
  logic [7:0]  sr_b, sg_b, sb_b, pr_b, pg_b, pb_b;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(LAT_A), .X_W(12), .Y_W(12)
  ) dut_a (
    .clk_pix(clk_pix), .rst_n(rst_n), .en(en),
    .pix_req(req_a), .pix_x(x_a), .pix_y(y_a),
    .src_r(sr_a), .src_g(sg_a), .src_b(sb_a),
    .frame_start(fs_a), .line_start(ls_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a),
    .pix_r(pr_a), .pix_g(pg_a), .pix_b(pb_a)
  );

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .PIX_LAT(LAT_B), .X_W(12), .Y_W(12)
  ) dut_b (
    .clk_pix(clk_pix), .rst_n(rst_n), .en(en),
    .pix_req(req_b), .pix_x(x_b), .pix_y(y_b),
    .src_r(sr_b), .src_g(sg_b), .src_b(sb_b),
    .frame_start(fs_b), .line_start(ls_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b),
    .pix_r(pr_b), .pix_g(pg_b), .pix_b(pb_b)
  );

  // Pixel source: returns column/row/xor a fixed latency after each request, junk otherwise.
  logic [16:0] sp_a [LAT_A] = '{default: '0};
  logic [16:0] sp_b [LAT_B] = '{default: '0};

  always @(posedge clk_pix) begin
    sp_a[0] <= {req_a, x_a[7:0], y_a[7:0]};
    for (int i = 1; i < LAT_A; i++) sp_a[i] <= sp_a[i-1];
  end
  always @(posedge clk_pix) begin
    sp_b[0] <= {req_b, x_b[7:0], y_b[7:0]};
    for (int j = 1; j < LAT_B; j++) sp_b[j] <= sp_b[j-1];
  end

  assign sr_a = sp_a[LAT_A-1][16] ? sp_a[LAT_A-1][15:8] : 8'h5A;
  assign sg_a = sp_a[LAT_A-1][16] ? sp_a[LAT_A-1][7:0]  : 8'hC3;
  assign sb_a = sp_a[LAT_A-1][16] ? (sp_a[LAT_A-1][15:8] ^ sp_a[LAT_A-1][7:0]) : 8'h3C;
  assign sr_b = sp_b[LAT_B-1][16] ? sp_b[LAT_B-1][15:8] : 8'h5A;
  assign sg_b = sp_b[LAT_B-1][16] ? sp_b[LAT_B-1][7:0]  : 8'hC3;
  assign sb_b = sp_b[LAT_B-1][16] ? (sp_b[LAT_B-1][15:8] ^ sp_b[LAT_B-1][7:0]) : 8'h3C;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Every output at its reset value; dut_b has active-high sync so its idle level is 0.
  task automatic check_reset(input string nm);
    check({nm, "_a"}, 64'({req_a, fs_a, ls_a, de_a, hs_a, vs_a, x_a, y_a, pr_a, pg_a, pb_a}),
          64'({6'b000011, 48'h0}));
    check({nm, "_b"}, 64'({req_b, fs_b, ls_b, de_b, hs_b, vs_b, x_b, y_b, pr_b, pg_b, pb_b}),
          64'({6'b000000, 48'h0}));
  endtask

  // Reference model state and aligned-output scoreboard queues.
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   mh = 0;
  int   mv = 0;
  bit   m_rel = 1'b0;

  always @(negedge clk_pix) begin : chk
    exp_t e, ea, eb;
    bit live, act, hsb, vsb;
    logic [11:0] ex, ey;
    if (!rst_n) begin
      check_reset("rst_hold");
      qa.delete();
      qb.delete();
      repeat (LAT_A + 1) qa.push_back('0);
      repeat (LAT_B + 1) qb.push_back('0);
      m_rel = 1'b0;
      mh = 0;
      mv = 0;
    end else begin
      live = en && m_rel;
      act  = live && (mh < HA) && (mv < VA);
      hsb  = live && (mh >= HA + HF) && (mh < HA + HF + HSW);
      vsb  = live && (mv >= VA + VF) && (mv < VA + VF + VSW);
      ex   = act ? 12'(mh) : 12'h0;
      ey   = act ? 12'(mv) : 12'h0;
      check("stage0_a", 64'({req_a, fs_a, ls_a, x_a, y_a}),
            64'({act, live && mh == 0 && mv == 0, live && mh == 0, ex, ey}));
      check("stage0_b", 64'({req_b, fs_b, ls_b, x_b, y_b}),
            64'({act, live && mh == 0 && mv == 0, live && mh == 0, ex, ey}));
      e.act = act;
      e.hs  = hsb;
      e.vs  = vsb;
      e.r   = act ? 8'(mh) : 8'h00;
      e.g   = act ? 8'(mv) : 8'h00;
      e.b   = act ? 8'(mh ^ mv) : 8'h00;
      qa.push_back(e);
      qb.push_back(e);
      ea = qa.pop_front();
      eb = qb.pop_front();
      check("aligned_a", 64'({de_a, hs_a, vs_a, pr_a, pg_a, pb_a}),
            64'({ea.act, ~ea.hs, ~ea.vs, ea.r, ea.g, ea.b}));
      check("aligned_b", 64'({de_b, hs_b, vs_b, pr_b, pg_b, pb_b}),
            64'({eb.act, eb.hs, eb.vs, eb.r, eb.g, eb.b}));
      // Advance the model the same way the next clock edge will.
      m_rel = 1'b1;
      if (live) begin
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv++;
          if (mv == VT) mv = 0;
        end
      end else begin
        mh = 0;
        mv = 0;
      end
    end
  end

  // Enable phases with hand-derived pulse/request/DE counts over each window.
  typedef struct {
    bit en;
    int n;
    int fs;
    int ls;
    int req;
    int da;
    int db;
  } phase_t;

  phase_t tbl [5];

  initial begin : main
    bit found;
    int c_fs, c_ls, c_req, c_da, c_db;

    tbl[0] = '{1'b1, 2 * HT * VT, 2, 2 * VT, 2 * HA * VA, 2 * HA * VA, 2 * HA * VA};
    tbl[1] = '{1'b0, 50, 0, 0, 0, 0, 0};
    tbl[2] = '{1'b1, 3 * HT + 10, 1, 4, 58, 55, 52};   // abandoned mid-line
    tbl[3] = '{1'b0, 20, 0, 0, 0, 3, 6};               // DE tail of the abandoned line
    tbl[4] = '{1'b1, HT * VT, 1, VT, HA * VA, HA * VA, HA * VA};

    rst_n = 1'b1;
    en    = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset("rst_init");
    repeat (3) @(posedge clk_pix);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk_pix);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk_pix);
      #2 en = tbl[i].en;
      c_fs = 0; c_ls = 0; c_req = 0; c_da = 0; c_db = 0;
      repeat (tbl[i].n) begin
        @(negedge clk_pix);
        c_fs  += int'(fs_a);
        c_ls  += int'(ls_a);
        c_req += int'(req_a);
        c_da  += int'(de_a);
        c_db  += int'(de_b);
      end
      check($sformatf("p%0d_frame_start", i), 64'(c_fs),  64'(tbl[i].fs));
      check($sformatf("p%0d_line_start", i),  64'(c_ls),  64'(tbl[i].ls));
      check($sformatf("p%0d_pix_req", i),     64'(c_req), 64'(tbl[i].req));
      check($sformatf("p%0d_de_a", i),        64'(c_da),  64'(tbl[i].da));
      check($sformatf("p%0d_de_b", i),        64'(c_db),  64'(tbl[i].db));
    end

    // Drop enable at h=10, v=3 and watch the request and DE fall-off.
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge clk_pix);
      if (req_a && x_a == 12'd10 && y_a == 12'd3) found = 1'b1;
    end
    check("drop_point_reached", 64'(found), 64'(1));
    @(posedge clk_pix);
    #2 en = 1'b0;
    @(negedge clk_pix);
    check("drop_req_off", 64'({req_a, req_b}), 64'(0));
    @(negedge clk_pix);
    @(negedge clk_pix);
    check("drop_de_a_last", 64'(de_a), 64'(1));
    @(negedge clk_pix);
    check("drop_de_a_off", 64'(de_a), 64'(0));
    @(negedge clk_pix);
    @(negedge clk_pix);
    check("drop_de_b_last", 64'(de_b), 64'(1));
    @(negedge clk_pix);
    check("drop_de_b_off", 64'(de_b), 64'(0));

    // Re-enable: origin, request and frame pulse on the very first cycle.
    @(posedge clk_pix);
    #2 en = 1'b1;
    @(negedge clk_pix);
    check("reen_first", 64'({fs_a, ls_a, req_a, x_a, y_a}), 64'({3'b111, 24'h0}));

    // Asynchronous reset in the middle of an active line.
    repeat (40) @(negedge clk_pix);
    check("pre_rst_de_a", 64'(de_a), 64'(1));
    @(posedge clk_pix);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_async");
    repeat (3) @(posedge clk_pix);
    #2 rst_n = 1'b1;
    repeat (HT * VT + 20) @(negedge clk_pix);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
